ex_mem_pipe_reg: RTL
====================

# ex_mem_pipe_reg

Parametrised, clocked EX/MEM pipeline register for the five-stage core. It sits between the ALU stage and data memory and registers the EX results, control bits and the resolved branch target. It adds a valid/ready handshake with a two-entry skid buffer, synchronous flush, and bubble-safe gating of side-effecting controls.

## Interface
- DATA_W, 32, ALU result / store data / immediate width
- ADDR_W, 14, instruction address width; also the jump-target width
- REG_W, 5, destination register index width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset (one clock domain; async assert, active-low fixed)
- flush_i  in  1  synchronous kill of all held entries and of the current input
- in_valid_i  in  1  EX presents a valid instruction
- in_ready_o  out  1  stage can accept; equals NOT skid_full
- Zero_i, RegWrite_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  EX control/flags
- ALUResult_i, imme_i, rdata2_i  in  DATA_W each  ALU result, immediate, store data
- addr_i  in  ADDR_W  PC of the instruction
- rd_i  in  REG_W  destination register
- out_valid_o  out  1  MEM-facing entry valid
- out_ready_i  in  1  MEM consumes the entry
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, branch_taken_o  out  1 each  registered controls
- ALUResult_o, rdata2_o  out  DATA_W  registered data
- addr_jump_o  out  ADDR_W  branch target
- rd_o  out  REG_W  registered destination

## Operation
- Storage: main entry (drives outputs) plus skid entry. Each has a valid flag.
- Capture computes branch_taken = Branch_i & Zero_i and addr_jump = (addr_i + imme_i[ADDR_W-1:0]) mod 2^ADDR_W. Carry out is dropped.
- Push occurs when in_valid_i & in_ready_o & !flush_i. Pop occurs when out_valid_o & out_ready_i.
- Main empty, or popping: the push loads main directly. Otherwise the push loads skid.
- Pop with skid valid: skid moves to main in the same edge and skid empties.
- Skid full: in_ready_o=0 and no push is possible. A pop frees skid and in_ready_o rises on the next cycle.
- Gating: RegWrite_o, MemRead_o, MemWrite_o and branch_taken_o are ANDed with out_valid_o. A bubble can never write a register or memory, or redirect fetch. Data outputs hold their last value while invalid.
- flush_i: the next edge clears both valid flags and discards the input presented that cycle. flush_i has priority over push and pop.
- Reset: all outputs 0, both valid flags 0, in_ready_o=1 during and after reset.

## Timing
- Latency is 1 cycle from accept to out_valid_o when the stage is empty.
- Throughput is 1 per cycle while out_ready_i=1. Skid is never used in that case.
- A stall of out_ready_i for N≥1 cycles with continuous input:
  - the skid fills on the first stalled cycle;
  - in_ready_o=0 from the next cycle on.
- Release: on the first cycle out_ready_i=1, main pops and skid advances. in_ready_o=1 from the following cycle. No entry is lost or duplicated.
- Order is strictly FIFO.
- Reset mid-operation asynchronously drops all entries. The first push after deassertion appears one cycle later.

## Structure
- Package ex_mem_pkg holds:
  - default constants DATA_W_DEF=32, ADDR_W_DEF=14, REG_W_DEF=5;
  - packed struct ex_mem_ctrl_t {RegWrite, MemRead, MemWrite, MemtoReg, branch_taken}.
- Sub-module ex_mem_skid_buf (parameter PAYLOAD_W) implements the two-entry valid/ready buffer and flush. The top module packs and unpacks the payload and computes addr_jump/branch_taken.

## Test plan
- Reset then single push: ALUResult_i=0x1234, rd_i=3, RegWrite_i=1, out_ready_i=1 -> one cycle later out_valid_o=1, ALUResult_o=0x1234, rd_o=3, RegWrite_o=1; next cycle out_valid_o=0 and RegWrite_o=0.
- Branch target wrap: addr_i=0x3FFC, imme_i=8, Branch_i=1, Zero_i=1 -> addr_jump_o=0x0004, branch_taken_o=1. Repeat with Zero_i=0 -> branch_taken_o=0.
- Backpressure: push A, B, C each cycle with out_ready_i=0 from the cycle A appears -> A holds, B in skid, in_ready_o=0, C not accepted. Raise out_ready_i -> A, B, C emerge in order.
- Flush with both entries full and in_valid_i=1 -> next cycle out_valid_o=0, MemWrite_o=0, in_ready_o=1, and the flushed input never appears.
- Asynchronous reset asserted between edges with MemWrite_o=1 -> MemWrite_o and out_valid_o go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared defaults and control-bundle type for the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned REG_W_DEF  = 5;

    typedef struct packed {
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic MemtoReg;
        logic branch_taken;
    } ex_mem_ctrl_t;

    localparam int unsigned CTRL_W = $bits(ex_mem_ctrl_t);

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry valid/ready buffer: a main entry that drives the outputs plus
// one skid entry that absorbs the in-flight push when the consumer stalls.
module ex_mem_skid_buf #(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    logic                 main_valid;
    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] main_data;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 push;
    logic                 pop;

    assign in_ready_o  = ~skid_valid;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = main_valid & out_ready_i;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;

    // Occupancy flags; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            // skid_valid implies push is blocked, so at most one source refills main
            main_valid <= skid_valid | push;
            skid_valid <= 1'b0;
        end else if (push) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
            end else begin
                main_valid <= 1'b1;
            end
        end
    end

    // Payload movement; entries keep their contents when invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (!flush_i) begin
            if (pop && skid_valid) begin
                main_data <= skid_data;
            end else if (push && (!main_valid || pop)) begin
                main_data <= in_data_i;
            end
            if (push && main_valid && !pop) begin
                skid_data <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: computes branch outcome and target at capture,
// buffers the stage payload with backpressure, and gates side-effecting
// controls so a bubble can never write state or redirect fetch.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              Zero_i,
    input  logic              RegWrite_i,
    input  logic              Branch_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] imme_i,
    input  logic [DATA_W-1:0] rdata2_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [ADDR_W-1:0] addr_jump_o,
    output logic [REG_W-1:0]  rd_o
);

    localparam int unsigned PAYLOAD_W = CTRL_W + 2 * DATA_W + ADDR_W + REG_W;

    ex_mem_ctrl_t         ctrl_in;
    ex_mem_ctrl_t         ctrl_q;
    logic [ADDR_W-1:0]    addr_jump;
    logic [PAYLOAD_W-1:0] payload_in;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 valid_q;

    // Only the low ADDR_W immediate bits form the target; the rest are ignored.
    generate
        if (DATA_W > ADDR_W) begin : g_imm_hi
            logic unused_imme_hi;
            assign unused_imme_hi = ^imme_i[DATA_W-1:ADDR_W];
        end
    endgenerate

    // Capture-side branch resolution and payload packing.
    always_comb begin
        ctrl_in              = '0;
        ctrl_in.RegWrite     = RegWrite_i;
        ctrl_in.MemRead      = MemRead_i;
        ctrl_in.MemWrite     = MemWrite_i;
        ctrl_in.MemtoReg     = MemtoReg_i;
        ctrl_in.branch_taken = Branch_i & Zero_i;
        addr_jump            = addr_i + imme_i[ADDR_W-1:0];
        payload_in           = {ctrl_in, ALUResult_i, rdata2_i, addr_jump, rd_i};
    end

    ex_mem_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (payload_in),
        .out_valid_o (valid_q),
        .out_ready_i (out_ready_i),
        .out_data_o  (payload_q)
    );

    // Unpack the main entry and gate controls that have side effects.
    always_comb begin
        {ctrl_q, ALUResult_o, rdata2_o, addr_jump_o, rd_o} = payload_q;
        out_valid_o    = valid_q;
        RegWrite_o     = ctrl_q.RegWrite     & valid_q;
        MemRead_o      = ctrl_q.MemRead      & valid_q;
        MemWrite_o     = ctrl_q.MemWrite     & valid_q;
        branch_taken_o = ctrl_q.branch_taken & valid_q;
        MemtoReg_o     = ctrl_q.MemtoReg;
    end

endmodule
